// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiplier/divider.
// Holds the FSM state encoding, Booth digit select encoding and operand helpers.
package mult_div_pkg;

    localparam int WIDTH      = 32;
    localparam int ACC_W      = WIDTH + 1;
    localparam int PROD_W     = 66;
    localparam int MULT_ITERS = 16;
    localparam int DIV_ITERS  = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        BOOTH_ZERO,
        BOOTH_PM,
        BOOTH_P2M,
        BOOTH_MM,
        BOOTH_M2M
    } booth_sel_t;

    // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_sel_t booth_decode(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return BOOTH_PM;
            3'b011:         return BOOTH_P2M;
            3'b100:         return BOOTH_M2M;
            3'b101, 3'b110: return BOOTH_MM;
            default:        return BOOTH_ZERO;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mult_div_cla_adder.sv
// Add/subtract unit shared by the Booth accumulate, divider step and quotient negate.
// ext_sign is the sign bit of the exact (W+1)-bit result, so callers can absorb overflow.
module cla_adder
    import mult_div_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         ext_sign
);

    logic [W-1:0] b_eff;
    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W:0]   carry;

    always_comb begin
        b_eff    = sub ? ~b : b;
        gen      = a & b_eff;
        prop     = a ^ b_eff;
        carry[0] = sub;
        for (int i = 0; i < W; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum      = prop ^ carry[W-1:0];
        ext_sign = a[W-1] ^ b_eff[W-1] ^ carry[W];
    end

endmodule

// File: rtl/mult_div.sv
// Iterative signed 32-bit multiplier (radix-4 Booth, 16 steps) and divider
// (non-restoring, 32 steps); a start pulse launches, a one-cycle ready pulse reports.
module mult_div
    import mult_div_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_operandA,
    input  logic [WIDTH-1:0]  data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    output logic [WIDTH-1:0]  data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic [PROD_W-1:0] dbg_prod,
    output logic [ACC_W-1:0]  dbg_p2m,
    output logic [ACC_W-1:0]  dbg_pm,
    output logic [ACC_W-1:0]  dbg_mm,
    output logic [ACC_W-1:0]  dbg_m2m,
    output logic [PROD_W-1:0] dbg_sra_in,
    output logic [PROD_W-1:0] dbg_sra_out
);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  m;
    logic              is_div, neg_q, div_zero, div_ovf;

    logic [ACC_W-1:0]  m2;
    booth_sel_t        sel;
    logic [ACC_W-1:0]  add_a, add_b, add_sum;
    logic              add_sub, add_sign;
    logic [PROD_W-1:0] sra_in, sra_out;
    logic [WIDTH:0]    mult_hi;
    logic              mult_ovf;

    assign m2       = {m[ACC_W-2:0], 1'b0};
    assign sel      = booth_decode(prod[2:0]);
    assign sra_in   = {add_sum, prod[32:0]};
    // The exact sign of the add result is shifted in, so a +2^32 partial sum stays correct.
    assign sra_out  = {add_sign, add_sign, add_sum, prod[32:2]};
    assign mult_hi  = prod[64:32];
    assign mult_ovf = !((mult_hi == '0) || (mult_hi == '1));

    cla_adder #(.W(ACC_W)) u_adder (
        .a        (add_a),
        .b        (add_b),
        .sub      (add_sub),
        .sum      (add_sum),
        .ext_sign (add_sign)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state)
            MULT: begin
                add_a = prod[65:33];
                case (sel)
                    BOOTH_PM:  add_b = m;
                    BOOTH_P2M: add_b = m2;
                    BOOTH_MM:  begin add_b = m;  add_sub = 1'b1; end
                    BOOTH_M2M: begin add_b = m2; add_sub = 1'b1; end
                    default:   add_b = '0;
                endcase
            end
            DIV: begin
                add_a   = {prod[64:33], prod[31]};
                add_b   = m;
                add_sub = ~prod[65];
            end
            DONE: begin
                add_b   = {1'b0, prod[31:0]};
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        if (ctrl_MULT) begin
            next_state = MULT;
        end else if (ctrl_DIV) begin
            next_state = DIV;
        end else begin
            case (state)
                MULT:    if (cnt == CNT_W'(MULT_ITERS - 1)) next_state = DONE;
                DIV:     if (cnt == CNT_W'(DIV_ITERS - 1))  next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: registered state is always assigned with <= so all flops update together.
            state <= next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            prod           <= '0;
            m              <= '0;
            is_div         <= 1'b0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                cnt    <= '0;
                m      <= {data_operandA[WIDTH-1], data_operandA};
                prod   <= {{ACC_W{1'b0}}, data_operandB, 1'b0};
                is_div <= 1'b0;
            end else if (ctrl_DIV) begin
                cnt      <= '0;
                m        <= {1'b0, abs_val(data_operandB)};
                prod     <= {{ACC_W{1'b0}}, 1'b0, abs_val(data_operandA)};
                is_div   <= 1'b1;
                neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
            end else begin
                case (state)
                    MULT: begin
                        prod <= sra_out;
                        cnt  <= cnt + 1'b1;
                    end
                    DIV: begin
                        prod <= {add_sum, 1'b0, prod[30:0], ~add_sum[ACC_W-1]};
                        cnt  <= cnt + 1'b1;
                    end
                    DONE: begin
                        data_resultRDY <= 1'b1;
                        if (is_div) begin
                            data_result    <= div_zero ? '0 : (neg_q ? add_sum[WIDTH-1:0] : prod[WIDTH-1:0]);
                            data_exception <= div_zero | div_ovf;
                        end else begin
                            data_result    <= prod[WIDTH:1];
                            data_exception <= mult_ovf;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dbg_prod    = prod;
    assign dbg_pm      = m;
    assign dbg_p2m     = m2;
    assign dbg_mm      = -m;
    assign dbg_m2m     = -m2;
    assign dbg_sra_in  = sra_in;
    assign dbg_sra_out = sra_out;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed corner cases, randomized operands
// against an arithmetic reference model, abort-by-restart and async reset.
module tb_mult_div;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [65:0] dbg_prod, dbg_sra_in, dbg_sra_out;
    logic [32:0] dbg_p2m, dbg_pm, dbg_mm, dbg_m2m;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mult_div dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .dbg_prod       (dbg_prod),
        .dbg_p2m        (dbg_p2m),
        .dbg_pm         (dbg_pm),
        .dbg_mm         (dbg_mm),
        .dbg_m2m        (dbg_m2m),
        .dbg_sra_in     (dbg_sra_in),
        .dbg_sra_out    (dbg_sra_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit product and truncating integer division.
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc);
        longint p;
        if (!is_div) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            res = $signed(a) / $signed(b);
            exc = 1'b0;
        end
    endfunction

    task automatic start_op(input logic mul, input logic dv, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = dv;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!data_resultRDY && n < 100);
    endtask

    task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, input bit both = 1'b0);
        logic [31:0] exp_res;
        logic        exp_exc;
        int          n;
        model(is_div, a, b, exp_res, exp_exc);
        start_op(!is_div || both, is_div || both, a, b);
        wait_ready(n);
        check({tag, " latency"}, n, is_div ? 33 : 17);
        check({tag, " result"}, data_result, exp_res);
        check({tag, " exception"}, {31'b0, data_exception}, {31'b0, exp_exc});
        @(posedge clock);
        #1;
        check({tag, " pulse"}, {31'b0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        int          rdy_seen;

        #2 reset = 1'b1;
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'b0, data_exception}, 32'd0);
        check("reset ready", {31'b0, data_resultRDY}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        run_op("mult 7x-3", 1'b0, 32'd7, 32'hffff_fffd);
        run_op("mult 65536^2", 1'b0, 32'd65536, 32'd65536);
        run_op("mult min x 1", 1'b0, 32'h8000_0000, 32'd1);
        run_op("mult min x min", 1'b0, 32'h8000_0000, 32'h8000_0000);
        run_op("mult min x -1", 1'b0, 32'h8000_0000, 32'hffff_ffff);
        run_op("mult both ctrl", 1'b0, 32'd12345, 32'hffff_f000, 1'b1);
        run_op("div -7/2", 1'b1, 32'hffff_fff9, 32'd2);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7);
        run_op("div 5/0", 1'b1, 32'd5, 32'd0);
        run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hffff_ffff);
        run_op("div min/1", 1'b1, 32'h8000_0000, 32'd1);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) begin
                ra = {{16{ra[15]}}, ra[15:0]};
                rb = {{16{rb[15]}}, rb[15:0]};
            end
            run_op("rand mult", 1'b0, ra, rb);
        end
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = {{24{rb[7]}}, rb[7:0]};
            if (i % 3 == 2) rb = {{16{rb[15]}}, rb[15:0]};
            run_op("rand div", 1'b1, ra, rb);
        end

        start_op(1'b1, 1'b0, 32'd1234, 32'd5678);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check("interrupt quiet", {31'b0, data_resultRDY}, 32'd0);
        end
        run_op("interrupt div 9/3", 1'b1, 32'd9, 32'd3);

        run_op("div min/-1 again", 1'b1, 32'h8000_0000, 32'hffff_ffff);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (10) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        #1;
        check("mid reset result", data_result, 32'd0);
        check("mid reset exception", {31'b0, data_exception}, 32'd0);
        check("mid reset ready", {31'b0, data_resultRDY}, 32'd0);
        @(negedge clock) reset = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("no ready after reset", rdy_seen, 32'd0);
        run_op("post reset mult", 1'b0, 32'hffff_fff0, 32'd300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
